service_counter: RTL and testbench
==================================

SERVICE_COUNTER -- requirements
Module: service_counter

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 4, giving clock cycles per service time unit (legal range 1..65535).
REQ-002 The block SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port ld  input  1  load strobe from the dispatcher, one cycle wide.
REQ-005 The block SHALL have port dn  input  4  customer number accompanying ld.
REQ-006 The block SHALL have port dt  input  4  service time in time units accompanying ld.
REQ-007 The block SHALL have port busy  output  1  window occupied; the dispatcher issues no ld while it is high.
REQ-008 The block SHALL have port cur_num  output  4  number being served, or last number served.
REQ-009 The block SHALL have port remain  output  4  time units left in the current service.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse at end of service.
REQ-011 The block SHALL have ports served_cnt  output  8 and busy_cycles  output  16 only when SVC_STATS_EN is defined.

Function
REQ-012 The block SHALL use a state machine with states IDLE, SERVE and DONE, and all outputs SHALL be registered.
REQ-013 In IDLE with ld=1, the block SHALL capture dn into cur_num and dt into remain, and restart the prescaler at the same edge.
REQ-014 On that edge the block SHALL go to SERVE if dt!=0, or to DONE if dt==0.
REQ-015 busy SHALL be 1 in SERVE and DONE and 0 in IDLE, and SHALL rise on the same edge that samples ld.
REQ-016 ld SHALL be ignored in SERVE and DONE: no capture of dn or dt, and no state change.
REQ-017 The prescaler SHALL assert an internal tick every TICK_DIV cycles, counted from the ld edge; with TICK_DIV=1 it SHALL tick every cycle.
REQ-018 In SERVE, each tick SHALL decrement remain by 1, and the tick that makes remain 0 SHALL move the state to DONE.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, after which the state SHALL return to IDLE.
REQ-020 busy SHALL therefore stay high for exactly TICK_DIV*dt+1 cycles per accepted ld.
REQ-021 cur_num SHALL hold its value after DONE until the next accepted ld.
REQ-022 remain SHALL never underflow below 0.
REQ-023 The prescaler SHALL count only in SERVE and SHALL hold at 0 otherwise.

Reset
REQ-024 Asserting rst_n=0 at any time, including mid-service, SHALL immediately force state IDLE and busy=0, done=0, cur_num=0, remain=0, prescaler=0, and statistics=0.
REQ-025 The first ld SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-026 With macro SVC_STATS_EN defined, served_cnt SHALL increment, saturating at 255, on each DONE cycle.
REQ-027 With SVC_STATS_EN defined, busy_cycles SHALL increment, saturating at 65535, on every cycle in which busy=1.
REQ-028 Without SVC_STATS_EN, the statistics ports and their counters SHALL be absent, with all other behaviour identical.

Structure
REQ-029 A shared package svc_pkg SHALL hold the state enum (IDLE, SERVE, DONE) and the constants NUM_W=4, TIME_W=4, STAT_CNT_W=8 and STAT_CYC_W=16.
REQ-030 The prescaler SHALL be a sub-module named svc_tick_gen with inputs clk, rst_n, clr and en, and output tick.

Verification
REQ-031 The bench SHALL check: TICK_DIV=4, ld with dn=11, dt=2 -> busy high for 9 cycles, remain going 2,1,0, done pulsing in cycle 9, and cur_num=11 afterwards.
REQ-032 The bench SHALL check: ld with dn=12, dt=0 -> one DONE cycle with busy=1 and done=1, then IDLE.
REQ-033 The bench SHALL check: second ld with dn=13, dt=4 issued during SERVE of dn=11 -> ignored, so cur_num stays 11 and timing is unchanged.
REQ-034 The bench SHALL check: rst_n pulsed low at remain=1 mid-service -> busy, remain and cur_num read 0 immediately, and no done pulse occurs.
REQ-035 The bench SHALL check: with SVC_STATS_EN, 3 services with dt=1, TICK_DIV=4 -> served_cnt=3 and busy_cycles=15.
REQ-036 The bench SHALL check: TICK_DIV=1, dt=15 -> busy high for 16 cycles, and a back-to-back ld on the cycle after done is accepted.

Source files
------------

// File: rtl/svc_pkg.sv
// Shared types and widths for the service counter block.
package svc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } svc_state_e;

  localparam int NUM_W      = 4;
  localparam int TIME_W     = 4;
  localparam int STAT_CNT_W = 8;
  localparam int STAT_CYC_W = 16;

  localparam int PRESCALE_W = 16;

endpackage

// File: rtl/svc_tick_gen.sv
// Prescaler: pulses tick once every TICK_DIV enabled cycles, counted from clr.
module svc_tick_gen
  import svc_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [PRESCALE_W-1:0] TC = PRESCALE_W'(TICK_DIV - 1);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  // Terminal count is combinational so the FSM sees it on the TICK_DIV-th cycle.
  assign tick = en && (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/service_counter.sv
// Service window counter: loads a customer/time pair, counts it down, pulses done.
// Optional statistics ports are built when SVC_STATS_EN is defined.
//   state | meaning
//   IDLE  | window free, waiting for ld
//   SERVE | counting remain down once per tick
//   DONE  | one-cycle end-of-service, done asserted
module service_counter
  import svc_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld,
  input  logic [NUM_W-1:0]  dn,
  input  logic [TIME_W-1:0] dt,
  output logic              busy,
  output logic [NUM_W-1:0]  cur_num,
  output logic [TIME_W-1:0] remain,
  output logic              done
`ifdef SVC_STATS_EN
  ,
  output logic [STAT_CNT_W-1:0] served_cnt,
  output logic [STAT_CYC_W-1:0] busy_cycles
`endif
);

  svc_state_e        state_q, state_d;
  logic [NUM_W-1:0]  cur_num_q, cur_num_d;
  logic [TIME_W-1:0] remain_q, remain_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept;
  logic              tick;

  svc_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (state_q == SERVE),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    cur_num_d = cur_num_q;
    remain_d  = remain_q;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld) begin
          accept    = 1'b1;
          cur_num_d = dn;
          remain_d  = dt;
          state_d   = (dt == '0) ? DONE : SERVE;
        end
      end
      SERVE: begin
        if (tick) begin
          if (remain_q != '0) begin
            remain_d = remain_q - TIME_W'(1);
          end
          if (remain_q <= TIME_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered off the next state so they align with it.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_num_q <= '0;
      remain_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_num_q <= cur_num_d;
      remain_q  <= remain_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign cur_num = cur_num_q;
  assign remain  = remain_q;
  assign done    = done_q;

`ifdef SVC_STATS_EN
  logic [STAT_CNT_W-1:0] served_q, served_d;
  logic [STAT_CYC_W-1:0] busy_cyc_q, busy_cyc_d;

  always_comb begin
    served_d   = served_q;
    busy_cyc_d = busy_cyc_q;
    if (state_q == DONE && served_q != '1) begin
      served_d = served_q + STAT_CNT_W'(1);
    end
    if (busy_q && busy_cyc_q != '1) begin
      busy_cyc_d = busy_cyc_q + STAT_CYC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      served_q   <= '0;
      busy_cyc_q <= '0;
    end else begin
      served_q   <= served_d;
      busy_cyc_q <= busy_cyc_d;
    end
  end

  assign served_cnt  = served_q;
  assign busy_cycles = busy_cyc_q;
`endif

endmodule

// File: tb/tb_service_counter.sv
// Scoreboard bench for service_counter: TICK_DIV=4 instance (a) and TICK_DIV=1 instance (b).
module tb_service_counter;

  typedef struct {
    logic [3:0] num;
    int         len;
    int         rsum;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ld_a = 1'b0, ld_b = 1'b0;
  logic [3:0] dn_a = '0, dt_a = '0, dn_b = '0, dt_b = '0;
  logic       busy_a, done_a, busy_b, done_b;
  logic [3:0] cur_num_a, remain_a, cur_num_b, remain_b;
`ifdef SVC_STATS_EN
  logic [7:0]  served_a, served_b;
  logic [15:0] bcyc_a, bcyc_b;
`endif

  int n_vec = 0;
  int n_err = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  int len_a = 0, sum_a = 0, len_b = 0, sum_b = 0;

  always #5 clk = ~clk;

  service_counter #(.TICK_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .ld(ld_a), .dn(dn_a), .dt(dt_a),
    .busy(busy_a), .cur_num(cur_num_a), .remain(remain_a), .done(done_a)
`ifdef SVC_STATS_EN
    , .served_cnt(served_a), .busy_cycles(bcyc_a)
`endif
  );

  service_counter #(.TICK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .ld(ld_b), .dn(dn_b), .dt(dt_b),
    .busy(busy_b), .cur_num(cur_num_b), .remain(remain_b), .done(done_b)
`ifdef SVC_STATS_EN
    , .served_cnt(served_b), .busy_cycles(bcyc_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Monitors: accumulate busy length and remain sum per service, compare on done.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      len_a = 0; sum_a = 0;
    end else if (busy_a) begin
      len_a++; sum_a += int'(remain_a);
      if (done_a) begin
        if (q_a.size() == 0) chk("a_unexpected_done", 1, 0);
        else begin
          e = q_a.pop_front();
          chk("a_num", cur_num_a, e.num);
          chk("a_busy_len", len_a, e.len);
          chk("a_remain_sum", sum_a, e.rsum);
        end
        len_a = 0; sum_a = 0;
      end
    end else if (done_a) chk("a_done_while_idle", 1, 0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      len_b = 0; sum_b = 0;
    end else if (busy_b) begin
      len_b++; sum_b += int'(remain_b);
      if (done_b) begin
        if (q_b.size() == 0) chk("b_unexpected_done", 1, 0);
        else begin
          e = q_b.pop_front();
          chk("b_num", cur_num_b, e.num);
          chk("b_busy_len", len_b, e.len);
          chk("b_remain_sum", sum_b, e.rsum);
        end
        len_b = 0; sum_b = 0;
      end
    end else if (done_b) chk("b_done_while_idle", 1, 0);
  end

  task automatic issue_a(input logic [3:0] n, input logic [3:0] t, input bit expect_done);
    exp_t e;
    if (expect_done) begin
      e.num = n; e.len = 4 * int'(t) + 1; e.rsum = 4 * int'(t) * (int'(t) + 1) / 2;
      q_a.push_back(e);
    end
    ld_a = 1'b1; dn_a = n; dt_a = t;
    @(posedge clk); #1;
    ld_a = 1'b0;
  endtask

  task automatic issue_b(input logic [3:0] n, input logic [3:0] t);
    exp_t e;
    e.num = n; e.len = int'(t) + 1; e.rsum = int'(t) * (int'(t) + 1) / 2;
    q_b.push_back(e);
    ld_b = 1'b1; dn_b = n; dt_b = t;
    @(posedge clk); #1;
    ld_b = 1'b0;
  endtask

  task automatic wait_idle_a();
    int i;
    for (i = 0; i < 200; i++) begin
      if (!busy_a) break;
      @(posedge clk); #1;
    end
    if (i == 200) chk("a_idle_timeout", 1, 0);
  endtask

  task automatic wait_idle_b();
    int i;
    for (i = 0; i < 200; i++) begin
      if (!busy_b) break;
      @(posedge clk); #1;
    end
    if (i == 200) chk("b_idle_timeout", 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_cur_num", cur_num_a, 0);
    chk("rst_remain", remain_a, 0);
    chk("rst_b_busy", busy_b, 0);
`ifdef SVC_STATS_EN
    chk("rst_served", served_a, 0);
    chk("rst_busy_cycles", bcyc_a, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // dn=11 dt=2, with a second ld attempted mid-service that must be ignored
    issue_a(4'd11, 4'd2, 1'b1);
    chk("a1_busy_rise", busy_a, 1);
    chk("a1_remain_load", remain_a, 2);
    chk("a1_cur_num_load", cur_num_a, 11);
    @(posedge clk); #1;
    ld_a = 1'b1; dn_a = 4'd13; dt_a = 4'd4;
    @(posedge clk); #1;
    ld_a = 1'b0;
    chk("a1_ignored_num", cur_num_a, 11);
    chk("a1_ignored_remain", remain_a, 2);
    repeat (2) @(posedge clk);
    #1;
    chk("a1_remain_cycle5", remain_a, 1);
    wait_idle_a();
    chk("a1_cur_num_hold", cur_num_a, 11);
    chk("a1_remain_end", remain_a, 0);
    repeat (2) @(posedge clk);
    #1;

    // dn=12 dt=0: straight to a single DONE cycle
    issue_a(4'd12, 4'd0, 1'b1);
    chk("a2_busy", busy_a, 1);
    chk("a2_done", done_a, 1);
    chk("a2_remain", remain_a, 0);
    @(posedge clk); #1;
    chk("a2_busy_after", busy_a, 0);
    chk("a2_done_after", done_a, 0);
    chk("a2_num_hold", cur_num_a, 12);

    // reset mid-service once remain reaches 1; the aborted service must not pulse done
    issue_a(4'd5, 4'd2, 1'b0);
    for (i = 0; i < 50; i++) begin
      if (remain_a == 4'd1) break;
      @(posedge clk); #1;
    end
    chk("a3_reached_remain1", remain_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("a3_rst_busy", busy_a, 0);
    chk("a3_rst_remain", remain_a, 0);
    chk("a3_rst_cur_num", cur_num_a, 0);
    chk("a3_rst_done", done_a, 0);
`ifdef SVC_STATS_EN
    chk("a3_rst_served", served_a, 0);
    chk("a3_rst_busy_cycles", bcyc_a, 0);
`endif
    repeat (2) @(posedge clk);
    #1;

    // first ld accepted on the first edge after release, then three dt=1 services
    rst_n = 1'b1;
    issue_a(4'd1, 4'd1, 1'b1);
    chk("a4_first_ld_busy", busy_a, 1);
    chk("a4_first_ld_num", cur_num_a, 1);
    wait_idle_a();
    issue_a(4'd2, 4'd1, 1'b1);
    wait_idle_a();
    issue_a(4'd3, 4'd1, 1'b1);
    wait_idle_a();
    chk("a4_last_num", cur_num_a, 3);
`ifdef SVC_STATS_EN
    chk("a4_served_cnt", served_a, 3);
    chk("a4_busy_cycles", bcyc_a, 15);
`endif

    // TICK_DIV=1, dt=15, then back-to-back ld on the cycle after done
    issue_b(4'd14, 4'd15);
    chk("b1_busy_rise", busy_b, 1);
    chk("b1_remain_load", remain_b, 15);
    for (i = 0; i < 40; i++) begin
      if (done_b) break;
      @(posedge clk); #1;
    end
    chk("b1_done_seen", done_b, 1);
    @(posedge clk); #1;
    chk("b1_idle_after_done", busy_b, 0);
    issue_b(4'd7, 4'd1);
    chk("b2_accepted_busy", busy_b, 1);
    chk("b2_accepted_num", cur_num_b, 7);
    wait_idle_b();
    repeat (2) @(posedge clk);
    #1;

    chk("a_queue_empty", q_a.size(), 0);
    chk("b_queue_empty", q_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
